// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline-stage register with 2-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
    parameter int                 DATA_W     = 96,
    parameter logic [DATA_W-1:0]  RESET_DATA = {DATA_W{1'b0}},
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              ready_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_fire;
    logic              out_fire;
    logic              stalled;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = main_valid & out_ready;
    assign stalled  = main_valid & ~out_ready;

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    assign stall_cnt = cnt_q;

    // ready_q mirrors ~skid_valid as its own flop so upstream sees no logic after it
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RESET_DATA;
            skid_data  <= RESET_DATA;
            ready_q    <= 1'b1;
            cnt_q      <= '0;
        end else begin
            if (stalled && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                main_data  <= RESET_DATA;
                skid_data  <= RESET_DATA;
                ready_q    <= 1'b1;
            end else begin
                case ({skid_valid, main_valid})
                    2'b00: begin
                        if (in_fire) begin
                            main_data  <= in_data;
                            main_valid <= 1'b1;
                        end
                    end
                    2'b01: begin
                        if (out_fire && in_fire) begin
                            main_data <= in_data;
                        end else if (out_fire) begin
                            main_valid <= 1'b0;
                            main_data  <= RESET_DATA;
                        end else if (in_fire) begin
                            skid_data  <= in_data;
                            skid_valid <= 1'b1;
                            ready_q    <= 1'b0;
                        end
                    end
                    2'b11: begin
                        if (out_fire) begin
                            main_data  <= skid_data;
                            skid_valid <= 1'b0;
                            skid_data  <= RESET_DATA;
                            ready_q    <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid with a queue reference model
module tb_pipe_stage_skid;

    localparam int          DW = 96;
    localparam int          CW = 4;
    localparam logic [DW-1:0] RD = 96'hDEAD_BEEF_0000_0000_CAFE_F00D;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    pipe_stage_skid #(.DATA_W(DW), .RESET_DATA(RD), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    int            total = 0;
    int            bad = 0;
    bit            started = 0;
    int            model_cnt = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of upstream/downstream stimulus; the model queue follows the accepted payloads
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic rs, output bit fired);
        in_valid = v; in_data = d; out_ready = r; flush = f; reset = rs;
        @(negedge clk);
        fired = in_valid & in_ready;
        @(posedge clk);
        if (rs || f) q.delete();
        else if (fired) q.push_back(d);
        if (rs) started = 1;
        #1;
    endtask

    // Monitor: occupancy/ready/valid against queue size, head payload on out_fire, stall counter
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("occupancy", 128'(occupancy), 128'(q.size()));
                check("in_ready", 128'(in_ready), 128'(q.size() < 2));
                check("out_valid", 128'(out_valid), 128'(q.size() > 0));
                if (!out_valid) check("idle_data", 128'(out_data), 128'(RD));
                check("stall_cnt", 128'(stall_cnt), 128'(model_cnt));
                if (prev_stall) check("hold_data", 128'(out_data), 128'(prev_data));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) check("unexpected_out", 128'(out_data), 128'(RD));
                    else check("out_data", 128'(out_data), 128'(q.pop_front()));
                end
                prev_stall = out_valid && !out_ready && !flush && !reset;
                prev_data  = out_data;
                if (reset) model_cnt = 0;
                else if (out_valid && !out_ready && model_cnt < (1 << CW) - 1) model_cnt++;
            end
        end
    end

    initial begin
        bit            fired;
        bit            hold;
        logic          v;
        logic [DW-1:0] d;
        @(posedge clk); #1;
        step(0, '0, 1, 0, 1, fired);
        step(0, '0, 1, 0, 1, fired);
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 1, 0, 0, fired);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, fired);

        step(1, DW'('h11), 0, 0, 0, fired);
        step(1, DW'('h22), 0, 0, 0, fired);
        for (int i = 0; i < 3; i++) begin
            step(1, DW'('h33), 0, 0, 0, fired);
            check("c_blocked", 128'(fired), 128'(0));
        end
        fired = 0;
        for (int i = 0; i < 5 && !fired; i++) step(1, DW'('h33), 1, 0, 0, fired);
        check("c_accepted", 128'(fired), 128'(1));
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0, fired);

        step(1, DW'('h55), 0, 0, 0, fired);
        step(1, DW'('h66), 1, 0, 0, fired);
        check("simul_fire", 128'(fired), 128'(1));
        step(0, '0, 1, 0, 0, fired);

        step(1, DW'('hA1), 0, 0, 0, fired);
        step(1, DW'('hB2), 0, 0, 0, fired);
        step(1, DW'('h77), 0, 1, 0, fired);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, fired);

        step(1, DW'('h99), 0, 0, 0, fired);
        for (int i = 0; i < 20; i++) step(0, '0, 0, 0, 0, fired);
        check("stall_sat", 128'(stall_cnt), 128'(15));
        step(0, '0, 0, 0, 1, fired);
        step(0, '0, 1, 0, 0, fired);

        step(1, DW'('h42), 1, 0, 0, fired);
        step(1, DW'('h43), 0, 1, 1, fired);
        check("rst_flush_occ", 128'(occupancy), 128'(0));
        check("rst_flush_data", 128'(out_data), 128'(RD));

        hold = 0; v = 0; d = '0;
        for (int i = 0; i < 600; i++) begin
            logic r, f, rs;
            if (!hold) begin
                v = ($urandom % 4) != 0;
                d = {$urandom, $urandom, $urandom};
            end
            r  = (i % 100 < 50) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            f  = ($urandom % 40) == 0;
            rs = ($urandom % 150) == 0;
            step(v, d, r, f, rs, fired);
            hold = v && !fired && !f && !rs;
        end
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0, fired);
        check("drained", 128'(q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed Instr/PC4/PC8 inter-stage registers. Generic pipeline-stage register with a valid/ready handshake in place of a raw stall level.
- A 2-entry skid buffer gives full throughput with a registered upstream ready.
- Synchronous flush inserts a bubble (the RESET_DATA payload, a NOP for the instruction field) and discards everything in flight.
- Saturating stall-cycle counter for performance debug.
- Instantiated between F/D, D/E, E/M and M/W with the payload bundle concatenated into `in_data`.

Parameters:
- DATA_W, 96, payload width (e.g. Instr + PC4 + PC8 = 3×32).
- RESET_DATA, {DATA_W{1'b0}}, payload value loaded on reset/flush; 0 encodes a NOP.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch mispredict / exception).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; driven directly from a flop (no combinational path from out_ready).
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  head payload; equals RESET_DATA whenever out_valid=0 after reset/flush.
- occupancy  out  2  live entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main register (drives out_data/out_valid) and skid register, each with its own valid bit.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~skid_valid, taken from the registered skid valid bit.
- Reset (highest priority):
  - main_valid = skid_valid = 0; main/skid data = RESET_DATA.
  - in_ready = 1, occupancy = 0, stall_cnt = 0.
- Flush (priority below reset, above all handshakes):
  - Next edge sets both valid bits to 0 and both data registers to RESET_DATA.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed downstream; the block takes no further action.
  - in_ready = 1 on the following cycle. stall_cnt is not cleared.
- State transitions (occupancy), evaluated when neither reset nor flush is asserted:
  - 0 (EMPTY):
    - in_fire → main ← in_data, occupancy 1.
    - Otherwise hold.
  - 1 (ONE):
    - out_fire & in_fire → main ← in_data, occupancy stays 1.
    - out_fire only → main_valid ← 0, main data ← RESET_DATA, occupancy 0.
    - in_fire only → skid ← in_data, occupancy 2; in_ready = 0 next cycle.
    - Neither → hold.
  - 2 (TWO), in_ready = 0:
    - out_fire → main ← skid, skid_valid ← 0, skid data ← RESET_DATA, occupancy 1.
    - Otherwise hold.
- Latency: payload accepted at edge N appears on out_data/out_valid right after edge N when the main register is free or draining; otherwise after the older entry leaves.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush/reset.
- Throughput: 1 transfer/cycle sustained when out_ready=1 continuously.
- Data stability: out_data and out_valid do not change while out_valid=1 and out_ready=0, except under flush/reset.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Only reset clears it.
- Illegal input: in_valid with in_ready=0 is ignored; upstream must hold in_data/in_valid until in_fire.

Test Plan:
- Reset then stream: reset 2 cycles, then in_data=1,2,3,4 on consecutive cycles, out_ready=1 → out_data 1,2,3,4 each one cycle after acceptance, occupancy stays ≤1, in_ready constantly 1, stall_cnt=0.
- Backpressure fill:
  - out_ready=0, push A=0x11, B=0x22 → occupancy 2, in_ready=0.
  - C=0x33 held on input is not accepted; stall_cnt increments each blocked cycle.
  - out_ready=1 → out_data 0x11, 0x22, 0x33 in order, in_ready returns to 1 one cycle after the first drain.
- Simultaneous fire at occupancy 1: main=0x55, in_data=0x66, both fires same cycle → out_data=0x66 next cycle, occupancy 1, skid unused.
- Flush with two entries held: occupancy 2, flush=1 with in_valid=1 (0x77) → next cycle out_valid=0, out_data=RESET_DATA, occupancy 0, in_ready=1; 0x77 never appears on the output.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 and holds; reset mid-stall → stall_cnt=0, out_valid=0 the next cycle.
- Reset during flush and traffic: reset=1, flush=1, in_valid=1 in the same cycle → reset state exactly (occupancy 0, RESET_DATA, stall_cnt 0).
